// File: rtl/cla_pkg.sv
// Shared carry look-ahead helpers: group defaults, stage-count arithmetic and group P/G.
package cla_pkg;

    localparam int unsigned CLA_GROUP     = 4;
    localparam int unsigned CLA_MAX_GROUP = 32;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    // Returns {P, G} over the low n bits; G is a flat sum of products so nothing ripples.
    function automatic logic [1:0] group_pg(input logic [CLA_MAX_GROUP-1:0] p,
                                            input logic [CLA_MAX_GROUP-1:0] g,
                                            input int unsigned              n);
        logic pp;
        logic gg;
        logic term;
        pp = 1'b1;
        gg = 1'b0;
        for (int unsigned i = 0; i < CLA_MAX_GROUP; i++) begin
            if (i < n) begin
                pp   = pp & p[i];
                term = g[i];
                for (int unsigned j = i + 1; j < CLA_MAX_GROUP; j++) begin
                    if (j < n) term = term & p[j];
                end
                gg = gg | term;
            end
        end
        return {pp, gg};
    endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit combinational look-ahead group: per-bit carries from p/g/cin, plus group P/G.
module cla_group
    import cla_pkg::*;
#(
    parameter int unsigned GROUP = CLA_GROUP
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             pg,
    output logic             gg
);

    logic [CLA_MAX_GROUP-1:0] p_ext;
    logic [CLA_MAX_GROUP-1:0] g_ext;
    logic [GROUP-1:0]         c;

    always_comb begin
        p_ext            = '0;
        g_ext            = '0;
        p_ext[GROUP-1:0] = p;
        g_ext[GROUP-1:0] = g;
    end

    // Group P/G is kept independent of cin so the stage look-ahead around it forms no loop.
    assign {pg, gg} = group_pg(p_ext, g_ext, GROUP);

    always_comb begin
        logic [1:0] pre;
        pre  = '0;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 1; i < GROUP; i++) begin
            pre  = group_pg(p_ext, g_ext, i);
            c[i] = pre[0] | (pre[1] & cin);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry look-ahead adder/subtractor: one slice of GROUPS_PER_STAGE groups per stage,
// registered carry between stages, global stall driven by the output handshake.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned GROUP            = CLA_GROUP,
    parameter int unsigned GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SLICE   = GROUP * GROUPS_PER_STAGE;
    localparam int unsigned NSTAGES = ceil_div(WIDTH, SLICE);

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             carry0;

    assign in_ready = out_ready || !out_valid;
    assign advance  = in_ready;
    assign b_eff    = sub ? ~b : b;
    assign carry0   = sub ? 1'b1 : cin;

    for (genvar k = 0; k < NSTAGES; k++) begin : stg
        localparam int unsigned LO  = k * SLICE;
        localparam int unsigned HI  = (LO + SLICE > WIDTH) ? WIDTH : LO + SLICE;
        localparam int unsigned SW  = HI - LO;
        localparam int unsigned NG  = SW / GROUP;
        localparam int unsigned OPW = WIDTH - LO;

        logic [OPW-1:0]   op_a;
        logic [OPW-1:0]   op_b;
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_nxt;
        logic [SW-1:0]    sp;
        logic [SW-1:0]    sg;
        logic [SW-1:0]    ss;
        logic [NG-1:0]    gp;
        logic [NG-1:0]    gg;
        logic [NG:0]      gc;
        logic             v_r;
        logic             c_r;
        logic [WIDTH-1:0] s_r;

        // Operand bits not yet summed travel with the beat, shrinking by one slice per stage.
        if (k == 0) begin : g_src
            assign op_a = a;
            assign op_b = b_eff;
            assign v_in = in_valid;
            assign c_in = carry0;
            assign s_in = '0;
        end else begin : g_src
            assign op_a = stg[k-1].g_rem.a_r;
            assign op_b = stg[k-1].g_rem.b_r;
            assign v_in = stg[k-1].v_r;
            assign c_in = stg[k-1].c_r;
            assign s_in = stg[k-1].s_r;
        end

        assign sp = op_a[SW-1:0] ^ op_b[SW-1:0];
        assign sg = op_a[SW-1:0] & op_b[SW-1:0];

        for (genvar j = 0; j < NG; j++) begin : grp
            cla_group #(.GROUP(GROUP)) u_group (
                .p   (sp[j*GROUP +: GROUP]),
                .g   (sg[j*GROUP +: GROUP]),
                .cin (gc[j]),
                .sum (ss[j*GROUP +: GROUP]),
                .pg  (gp[j]),
                .gg  (gg[j])
            );
        end

        always_comb begin : lookahead
            logic [CLA_MAX_GROUP-1:0] pv;
            logic [CLA_MAX_GROUP-1:0] gv;
            logic [1:0]               la;
            pv         = '0;
            gv         = '0;
            la         = '0;
            pv[NG-1:0] = gp;
            gv[NG-1:0] = gg;
            gc         = '0;
            gc[0]      = c_in;
            for (int unsigned j = 1; j <= NG; j++) begin
                la    = group_pg(pv, gv, j);
                gc[j] = la[0] | (la[1] & c_in);
            end
        end

        always_comb begin
            s_nxt         = s_in;
            s_nxt[HI-1:LO] = ss;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (advance) begin
                v_r <= v_in;
                c_r <= gc[NG];
                s_r <= s_nxt;
            end
        end

        if (OPW > SW) begin : g_rem
            logic [OPW-SW-1:0] a_r;
            logic [OPW-SW-1:0] b_r;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (advance) begin
                    a_r <= op_a[OPW-1:SW];
                    b_r <= op_b[OPW-1:SW];
                end
            end
        end

        if (k == NSTAGES - 1) begin : g_last
            logic c_msb;
            logic ov_r;
            assign c_msb = op_a[OPW-1] ^ op_b[OPW-1] ^ ss[SW-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ov_r <= 1'b0;
                end else if (advance) begin
                    ov_r <= c_msb ^ gc[NG];
                end
            end
        end
    end

    assign out_valid = stg[NSTAGES-1].v_r;
    assign sum       = stg[NSTAGES-1].s_r;
    assign cout      = stg[NSTAGES-1].c_r;
    assign overflow  = stg[NSTAGES-1].g_last.ov_r;
    assign zero      = (sum == '0);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: 16-bit/4-stage main instance with directed and
// random traffic, plus 32-bit and 12-bit (narrow top stage) instances under random traffic.
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    longint      cyc   = 0;
    bit          stop_rnd = 1'b0;

    always @(posedge clk) cyc++;

    // {zero, overflow, cout, sum[31:0]} from plain integer arithmetic on w-bit operands
    function automatic logic [34:0] model(input int unsigned w, input logic [31:0] x,
                                          input logic [31:0] y, input logic ci, input logic op_sub);
        longint m, half, ux, uy, sx, sy, r, sr;
        logic [31:0] s;
        logic co, ov;
        m    = longint'(64'd1 << w);
        half = m / 2;
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = x[w-1] ? ux - m : ux;
        sy   = y[w-1] ? uy - m : uy;
        if (op_sub) begin
            r  = ux - uy;
            co = (r >= 0);
            sr = sx - sy;
        end else begin
            r  = ux + uy + longint'(ci);
            co = (r >= m);
            sr = sx + sy + longint'(ci);
        end
        s  = 32'(r & (m - 1));
        ov = (sr >= half) || (sr < -half);
        return {(s == 32'd0), ov, co, s};
    endfunction

    function automatic logic [31:0] rnd_val(input int unsigned w);
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom % 8)
            0:       return 32'd0;
            1:       return mask;
            2:       return 32'd1 << (w - 1);
            3:       return (32'd1 << (w - 1)) - 32'd1;
            4:       return 32'd1;
            default: return $urandom & mask;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- main instance: WIDTH=16, GROUP=4, GROUPS_PER_STAGE=1 ----------------
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow, zero;
    logic [15:0] a, b, sum;

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4), .GROUPS_PER_STAGE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .overflow(overflow), .zero(zero)
    );

    logic [34:0] sb_q[$];
    longint      acc_q[$];
    int unsigned acc_cnt = 0;
    bit          lat_exact = 1'b0;
    bit          stalled = 1'b0;
    logic [34:0] held;

    always @(negedge clk) begin : main_push
        if (rst) begin
            sb_q.delete();
            acc_q.delete();
        end else if (in_valid && in_ready) begin
            sb_q.push_back(model(16, 32'(a), 32'(b), cin, sub));
            acc_q.push_back(cyc);
            acc_cnt++;
        end
    end

    always @(negedge clk) begin : main_mon
        logic [34:0] act, exp;
        longint      lat;
        act = {zero, overflow, cout, 16'h0, sum};
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_result", 64'(act), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got sum %0h with empty scoreboard required none", sum);
                end else begin
                    exp = sb_q.pop_front();
                    lat = cyc - acc_q.pop_front();
                    check("result", 64'(act), 64'(exp));
                    if (lat_exact) check("latency", 64'(lat), 64'd4);
                end
            end
            stalled = out_valid && !out_ready;
            held    = act;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vs);
        a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready 0 required 1 within 50 cycles");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_next(input string name, input logic [15:0] es, input logic ec,
                               input logic eo, input logic ez);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                seen = 1'b1;
                check({name, "_sum"}, 64'(sum), 64'(es));
                check({name, "_cout"}, 64'(cout), 64'(ec));
                check({name, "_ovf"}, 64'(overflow), 64'(eo));
                check({name, "_zero"}, 64'(zero), 64'(ez));
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no out_valid required one within 20 cycles", name);
        end
        tick();
    endtask

    // ---------------- extra instances under random traffic ----------------
    for (genvar d = 0; d < 2; d++) begin : ext
        localparam int unsigned W = (d == 0) ? 32 : 12;

        logic         iv, ir, ci, sb, ov_, orr, co, of, zr;
        logic [W-1:0] xa, xb, xs;
        logic [34:0]  q[$];

        pipelined_cla_adder #(.WIDTH(W), .GROUP(4), .GROUPS_PER_STAGE(2)) u_dut (
            .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(xa), .b(xb),
            .cin(ci), .sub(sb), .out_valid(ov_), .out_ready(orr), .sum(xs),
            .cout(co), .overflow(of), .zero(zr)
        );

        initial begin
            iv = 1'b0; orr = 1'b0; ci = 1'b0; sb = 1'b0; xa = '0; xb = '0;
            forever begin
                tick();
                if (rst || stop_rnd) begin
                    iv  = 1'b0;
                    orr = 1'b1;
                end else begin
                    iv  = ($urandom % 3) != 0;
                    orr = ($urandom % 4) != 0;
                    xa  = W'(rnd_val(W));
                    xb  = W'(rnd_val(W));
                    ci  = $urandom % 2;
                    sb  = $urandom % 2;
                end
            end
        end

        always @(negedge clk) begin : push
            if (rst) q.delete();
            else if (iv && ir) q.push_back(model(W, 32'(xa), 32'(xb), ci, sb));
        end

        always @(negedge clk) begin : mon
            if (!rst && ov_ && orr) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ext%0d_unexpected_output: got sum %0h required none", W, xs);
                end else begin
                    check($sformatf("ext%0d_result", W), 64'({zr, of, co, 32'(xs)}), 64'(q.pop_front()));
                end
            end
        end

        initial begin
            wait (stop_rnd);
            repeat (12) tick();
            check($sformatf("ext%0d_drain", W), 64'(q.size()), 64'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish required finish before 1ms");
        $fatal(1, "simulation time limit");
    end

    // ---------------- directed sequence, then random ----------------
    initial begin : main_seq
        int unsigned base, cnt;
        int          first, last;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // wrap, signed overflow in both modes, borrow-free zero, carry across groups
        out_ready = 1'b1;
        lat_exact = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0); expect_next("wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0); expect_next("addovf", 16'h8000, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 16'h0001, 1'b1, 1'b1); expect_next("subovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);
        send(16'h0000, 16'h0000, 1'b0, 1'b1); expect_next("zerosub", 16'h0000, 1'b1, 1'b0, 1'b1);
        send(16'h0FFF, 16'h0000, 1'b1, 1'b0); expect_next("cinprop", 16'h1000, 1'b0, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1); expect_next("borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0);

        // back-to-back 8 beats at full rate
        first = -1; last = -1; cnt = 0;
        fork
            for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            for (int i = 0; i < 24; i++) begin
                @(negedge clk);
                if (out_valid) begin
                    if (first < 0) first = i;
                    last = i;
                    cnt++;
                end
            end
        join
        check("b2b_count", 64'(cnt), 64'd8);
        check("b2b_contiguous", 64'(last - first + 1), 64'd8);
        tick();

        // stall with downstream blocked
        lat_exact = 1'b0;
        out_ready = 1'b0;
        base = acc_cnt;
        for (int i = 0; i < 4; i++) send(16'(i * 16'h1111), 16'h0101, 1'b0, 1'b0);
        a = 16'h4444; b = 16'h2222; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        check("stall_accepted", 64'(acc_cnt - base), 64'd4);
        tick();
        out_ready = 1'b1;
        send(16'h4444, 16'h2222, 1'b0, 1'b1);
        send(16'h5555, 16'hAAAB, 1'b0, 1'b0);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        check("stall_drain", 64'(sb_q.size()), 64'd0);

        // async reset with three beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'h1234 + 16'(i), 16'h0011, 1'b1, 1'b0);
        tick();
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_sum", 64'(sum), 64'd0);
        check("async_rst_zero", 64'(zero), 64'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("post_rst_no_stale", 64'(cnt), 64'd0);
        tick();

        // random traffic against the arithmetic model
        for (int i = 0; i < 6000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            a         = 16'(rnd_val(16));
            b         = 16'(rnd_val(16));
            cin       = $urandom % 2;
            sub       = $urandom % 2;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stop_rnd  = 1'b1;
        repeat (14) tick();
        check("main_drain", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
